// File: rtl/key_count6.sv
// Debounced up/down push-button counter (0..MAX_VALUE, wrapping) with synchronous parallel load.
// Define AUTO_REPEAT_EN to add hold-to-repeat events (REPEAT_DELAY / REPEAT_PERIOD).
module key_count6 #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_VALUE       = 63,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESETN,
    input  logic       KEY_UP,
    input  logic       KEY_DN,
    input  logic       LOAD,
    input  logic [5:0] SW,
    output logic [5:0] COUNT,
    output logic       UPD
);

    localparam int              DW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]      MAX     = 6'(MAX_VALUE);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] HREP = 2'd2;
`endif

    if (DEBOUNCE_CYCLES < 2 || MAX_VALUE < 1 || MAX_VALUE > 63 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_count6: parameter out of range");
    end

    // Bit 0 is the up key, bit 1 the down key; all key levels are active-low.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    state  [2];
    logic [1:0]    ev;
    logic [5:0]    load_val;

    assign raw      = {KEY_DN, KEY_UP};
    assign load_val = (SW > MAX) ? MAX : SW;

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int            HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            HW          = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold_cnt [2];

    // A release seen in the same cycle as a repeat deadline wins: no event.
    always_comb begin
        ev = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            case (state[i])
                IDLE:    ev[i] = !stable[i];
                HELD:    ev[i] = !stable[i] && (hold_cnt[i] == DELAY_LAST);
                HREP:    ev[i] = !stable[i] && (hold_cnt[i] == PERIOD_LAST);
                default: ev[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                case (state[i])
                    IDLE: begin
                        hold_cnt[i] <= '0;
                        if (!stable[i]) state[i] <= HELD;
                    end
                    HELD, HREP: begin
                        if (stable[i]) begin
                            state[i]    <= IDLE;
                            hold_cnt[i] <= '0;
                        end else if (ev[i]) begin
                            state[i]    <= HREP;
                            hold_cnt[i] <= '0;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + HW'(1);
                        end
                    end
                    default: begin
                        state[i]    <= IDLE;
                        hold_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end
`else
    always_comb begin
        ev = '0;
        for (int unsigned i = 0; i < 2; i++) ev[i] = (state[i] == IDLE) && !stable[i];
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < 2; i++) state[i] <= IDLE;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (state[i] == IDLE && !stable[i]) state[i] <= HELD;
                else if (state[i] != IDLE && stable[i]) state[i] <= IDLE;
            end
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            COUNT <= '0;
            UPD   <= 1'b0;
        end else begin
            UPD <= 1'b0;
            if (LOAD) begin
                COUNT <= load_val;
                UPD   <= (load_val != COUNT);
            end else if (ev[0] && !ev[1]) begin
                COUNT <= (COUNT == MAX) ? '0 : COUNT + 6'd1;
                UPD   <= 1'b1;
            end else if (ev[1] && !ev[0]) begin
                COUNT <= (COUNT == '0) ? MAX : COUNT - 6'd1;
                UPD   <= 1'b1;
            end
        end
    end

endmodule
